frequency_band_analyzer: RTL and testbench

// Multi-band successor to the two-frequency analyzer. Measures the period of sample_data between rising edges
// and sorts each period into one of NUM_BANDS linear frequency bands. Accumulates clock cycles per band over a

---
 rtl/frequency_band_analyzer.sv | 176 +++++++++++++++++
 tb/tb_frequency_band_analyzer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_band_analyzer.sv
// frequency_band_analyzer: measures the period of sample_data between rising edges,
// sorts each period into NUM_BANDS linear frequency bands and publishes per-band
// cycle totals once per fixed measurement window, with a one-cycle valid strobe.
module frequency_band_analyzer #(
    parameter int unsigned CLOCK         = 32'd50000000,
    parameter int unsigned F_MIN         = 32'd1000,
    parameter int unsigned F_STEP        = 32'd1000,
    parameter int unsigned NUM_BANDS     = 32'd4,
    parameter int unsigned WINDOW_CYCLES = 32'd50000000,
    parameter int unsigned COUNTER_WIDTH = 32'd32
) (
    input  logic                               clock,
    input  logic                               clear,
    input  logic                               enable,
    input  logic                               sample_data,
    output logic [NUM_BANDS*COUNTER_WIDTH-1:0] band_values,
    output logic [COUNTER_WIDTH-1:0]           out_of_range_value,
    output logic                               values_valid,
    output logic                               saturated
);
    localparam int unsigned CW = COUNTER_WIDTH;

    // Period threshold (floor, in clock cycles) of band edge k.
    function automatic logic [63:0] threshold(input int unsigned k);
        return 64'(CLOCK) / (64'(F_MIN) + 64'(k) * 64'(F_STEP));
    endfunction

    localparam logic [63:0]      T_TOP  = threshold(32'd0);
    localparam int unsigned      PW     = $clog2(T_TOP + 64'd2);
    localparam logic [PW-1:0]    P_SAT  = PW'(T_TOP + 64'd1);
    localparam int unsigned      WW     = $clog2(WINDOW_CYCLES);
    localparam logic [WW-1:0]    W_LAST = WW'(WINDOW_CYCLES - 32'd1);
    localparam int unsigned      SW     = ((CW > PW) ? CW : PW) + 32'd1;

    if ((F_MIN == 32'd0) || (NUM_BANDS < 32'd1) || (NUM_BANDS > 32'd16) ||
        (WINDOW_CYCLES < 32'd2) ||
        (64'(CLOCK) < 64'd2 * (64'(F_MIN) + 64'(NUM_BANDS) * 64'(F_STEP)))) begin : g_bad_params
        $error("frequency_band_analyzer: illegal parameter combination");
    end

    // Saturating accumulate; bit CW of the result flags that the ceiling was hit.
    function automatic logic [CW:0] sat_add(input logic [CW-1:0] acc, input logic [PW-1:0] p);
        logic [SW-1:0] sum;
        sum = SW'(acc) + SW'(p);
        if (sum > SW'({CW{1'b1}})) begin
            return {1'b1, {CW{1'b1}}};
        end else begin
            return {1'b0, sum[CW-1:0]};
        end
    endfunction

    logic [2:0]    sync_r;
    logic [PW-1:0] period_r;
    logic          armed_r;
    logic          enable_d_r;
    logic [WW-1:0] window_r;
    logic [CW-1:0] acc_r [NUM_BANDS];
    logic [CW-1:0] oor_acc_r;
    logic          sat_r;

    logic          edge_s;
    logic          terminal_s;
    logic          classify_s;
    logic [63:0]   period_wide_s;
    logic [CW-1:0] acc_next_s [NUM_BANDS];
    logic [CW-1:0] oor_next_s;
    logic          sat_next_s;
    logic          in_band_s;
    logic [CW:0]   sum_s;

    assign edge_s        = sync_r[1] & ~sync_r[2];
    assign terminal_s    = enable & (window_r == W_LAST);
    assign classify_s    = enable & edge_s & armed_r;
    assign period_wide_s = 64'(period_r);

    // Classify the finished period and form the next accumulator contents.
    always_comb begin
        acc_next_s = acc_r;
        oor_next_s = oor_acc_r;
        sat_next_s = sat_r;
        in_band_s  = 1'b0;
        sum_s      = {(CW+1){1'b0}};
        if (classify_s) begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                if ((period_wide_s > threshold(k + 32'd1)) && (period_wide_s <= threshold(k))) begin
                    sum_s         = sat_add(acc_r[k], period_r);
                    acc_next_s[k] = sum_s[CW-1:0];
                    sat_next_s    = sat_r | sum_s[CW];
                    in_band_s     = 1'b1;
                end else begin
                    acc_next_s[k] = acc_r[k];
                end
            end
            if (!in_band_s) begin
                sum_s      = sat_add(oor_acc_r, period_r);
                oor_next_s = sum_s[CW-1:0];
                sat_next_s = sat_r | sum_s[CW];
            end else begin
                oor_next_s = oor_acc_r;
            end
        end else begin
            sat_next_s = sat_r;
        end
    end

    // Synchronizer, period counter, armed flag, window counter and valid strobe.
    always_ff @(posedge clock) begin
        if (clear) begin
            sync_r       <= 3'b000;
            period_r     <= {PW{1'b0}};
            armed_r      <= 1'b0;
            enable_d_r   <= 1'b0;
            window_r     <= {WW{1'b0}};
            values_valid <= 1'b0;
        end else begin
            sync_r     <= {sync_r[1:0], sample_data};
            enable_d_r <= enable;
            if (!enable) begin
                period_r     <= {PW{1'b0}};
                armed_r      <= 1'b0;
                window_r     <= {WW{1'b0}};
                values_valid <= 1'b0;
            end else begin
                values_valid <= terminal_s;
                window_r     <= terminal_s ? {WW{1'b0}} : (window_r + WW'(1));
                if (edge_s) begin
                    period_r <= PW'(1);
                    armed_r  <= 1'b1;
                end else if (period_r != P_SAT) begin
                    period_r <= period_r + PW'(1);
                end else begin
                    period_r <= period_r;
                end
            end
        end
    end

    // Accumulators and published snapshot.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                acc_r[k] <= {CW{1'b0}};
            end
            oor_acc_r          <= {CW{1'b0}};
            sat_r              <= 1'b0;
            band_values        <= {(NUM_BANDS*CW){1'b0}};
            out_of_range_value <= {CW{1'b0}};
            saturated          <= 1'b0;
        end else if (enable && !enable_d_r) begin
            // Fresh window after (re-)enable: drop whatever was partially gathered.
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                acc_r[k] <= {CW{1'b0}};
            end
            oor_acc_r <= {CW{1'b0}};
            sat_r     <= 1'b0;
        end else if (terminal_s) begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                band_values[k*CW +: CW] <= acc_next_s[k];
                acc_r[k]                <= {CW{1'b0}};
            end
            out_of_range_value <= oor_next_s;
            saturated          <= sat_next_s;
            oor_acc_r          <= {CW{1'b0}};
            sat_r              <= 1'b0;
        end else if (enable) begin
            acc_r     <= acc_next_s;
            oor_acc_r <= oor_next_s;
            sat_r     <= sat_next_s;
        end else begin
            acc_r     <= acc_r;
            oor_acc_r <= oor_acc_r;
            sat_r     <= sat_r;
        end
    end

endmodule

// File: tb/tb_frequency_band_analyzer.sv
// Directed bench for frequency_band_analyzer: a 32-bit instance exercises the band
// boundaries, timing and interruptions; an 8-bit instance shares clock/enable/clear
// and exercises accumulator saturation.
module tb_frequency_band_analyzer;
    localparam int unsigned NB  = 4;
    localparam int unsigned CW  = 32;
    localparam int unsigned CWB = 8;

    logic clock = 1'b0;
    logic clear, enable, sample_a, sample_b;
    logic [NB*CW-1:0]  band_a;
    logic [CW-1:0]     oor_a;
    logic              valid_a, sat_a;
    logic [NB*CWB-1:0] band_b;
    logic [CWB-1:0]    oor_b;
    logic              valid_b, sat_b;

    int checks, errors, cyc, phase, va_count, va_cyc, vb_count;
    logic wave_a, wave_b;

    always #5 clock = ~clock;

    frequency_band_analyzer #(
        .CLOCK(32'd100000), .F_MIN(32'd1000), .F_STEP(32'd1000), .NUM_BANDS(NB),
        .WINDOW_CYCLES(32'd10000), .COUNTER_WIDTH(CW)
    ) dut_a (
        .clock(clock), .clear(clear), .enable(enable), .sample_data(sample_a),
        .band_values(band_a), .out_of_range_value(oor_a),
        .values_valid(valid_a), .saturated(sat_a)
    );

    frequency_band_analyzer #(
        .CLOCK(32'd100000), .F_MIN(32'd1000), .F_STEP(32'd1000), .NUM_BANDS(NB),
        .WINDOW_CYCLES(32'd10000), .COUNTER_WIDTH(CWB)
    ) dut_b (
        .clock(clock), .clear(clear), .enable(enable), .sample_data(sample_b),
        .band_values(band_b), .out_of_range_value(oor_b),
        .values_valid(valid_b), .saturated(sat_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ba(input int k);
        return 64'(band_a[k*CW +: CW]);
    endfunction

    function automatic logic [63:0] bb(input int k);
        return 64'(band_b[k*CWB +: CWB]);
    endfunction

    // One clock: sample at the falling edge, then drive the next input values.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (valid_a === 1'b1) begin
            va_count++;
            va_cyc = cyc;
        end
        if (valid_b === 1'b1) vb_count++;
        phase++;
        if (wave_a) sample_a = ((phase % 40) >= 20) ? 1'b1 : 1'b0;
        if (wave_b) sample_b = ((phase % 40) >= 20) ? 1'b1 : 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_window(input logic wa, input logic wb);
        enable   = 1'b1;
        phase    = 0;
        cyc      = 0;
        wave_a   = wa;
        wave_b   = wb;
        sample_a = 1'b0;
        sample_b = 1'b0;
    endtask

    task automatic gap();
        enable   = 1'b0;
        wave_a   = 1'b0;
        wave_b   = 1'b0;
        sample_a = 1'b0;
        sample_b = 1'b0;
        steps(5);
    endtask

    // Runs until dut_a strobes valid, bounded; va_cyc stays -1 if it never does.
    task automatic run_to_valid();
        int start;
        start  = va_count;
        va_cyc = -1;
        for (int i = 0; (i < 10100) && (va_count == start); i++) step();
    endtask

    // Rising edge on sample_a, then wait g cycles until the next one may follow.
    task automatic pulse_a(input int g);
        sample_a = 1'b1;
        steps(5);
        sample_a = 1'b0;
        steps(g - 5);
    endtask

    initial begin
        int gaps2 [8];
        int gaps4 [2];
        int vbefore;
        gaps2 = '{50, 51, 33, 34, 25, 26, 20, 21};
        gaps4 = '{150, 10};
        checks = 0; errors = 0; cyc = 0; phase = 0;
        va_count = 0; va_cyc = 0; vb_count = 0;
        wave_a = 1'b0; wave_b = 1'b0;
        clear = 1'b1; enable = 1'b0; sample_a = 1'b0; sample_b = 1'b0;

        // Reset state
        steps(3);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_band1", ba(1), 64'd0);
        check("rst_oor", 64'(oor_a), 64'd0);
        check("rst_sat", 64'(sat_a), 64'd0);
        check("rst_b_band1", bb(1), 64'd0);
        clear = 1'b0;
        steps(2);

        // 1: 40-cycle square wave -> band 1 only; dut_b saturates
        start_window(1'b1, 1'b1);
        run_to_valid();
        check("t1_latency", 64'(va_cyc), 64'd10000);
        check("t1_band0", ba(0), 64'd0);
        check("t1_band1", ba(1), 64'd9960);
        check("t1_band2", ba(2), 64'd0);
        check("t1_band3", ba(3), 64'd0);
        check("t1_oor", 64'(oor_a), 64'd0);
        check("t1_sat", 64'(sat_a), 64'd0);
        check("t6_w1_b_band1", bb(1), 64'd255);
        check("t6_w1_b_band0", bb(0), 64'd0);
        check("t6_w1_b_sat", 64'(sat_b), 64'd1);
        step();
        check("t1_pulse_width", 64'(valid_a), 64'd0);
        check("t1_hold_band1", ba(1), 64'd9960);

        // 2: periods on the threshold boundaries
        gap();
        start_window(1'b0, 1'b1);
        steps(10);
        foreach (gaps2[i]) pulse_a(gaps2[i]);
        sample_a = 1'b1;
        steps(5);
        sample_a = 1'b0;
        run_to_valid();
        check("t2_latency", 64'(va_cyc), 64'd10000);
        check("t2_band0", ba(0), 64'd51);
        check("t2_band1", ba(1), 64'd84);
        check("t2_band2", ba(2), 64'd59);
        check("t2_band3", ba(3), 64'd46);
        check("t2_oor", 64'(oor_a), 64'd20);
        check("t6_w2_b_band1", bb(1), 64'd255);
        check("t6_w2_b_sat", 64'(sat_b), 64'd1);

        // 3: input held low -> empty snapshot still strobes
        gap();
        start_window(1'b0, 1'b0);
        run_to_valid();
        check("t3_latency", 64'(va_cyc), 64'd10000);
        check("t3_band0", ba(0), 64'd0);
        check("t3_band1", ba(1), 64'd0);
        check("t3_band2", ba(2), 64'd0);
        check("t3_band3", ba(3), 64'd0);
        check("t3_oor", 64'(oor_a), 64'd0);
        check("t6_w3_b_band1", bb(1), 64'd0);
        check("t6_w3_b_sat", 64'(sat_b), 64'd0);

        // 4: period 150 (counter saturates at 101) then period 10
        gap();
        start_window(1'b0, 1'b0);
        steps(10);
        foreach (gaps4[i]) pulse_a(gaps4[i]);
        sample_a = 1'b1;
        steps(5);
        sample_a = 1'b0;
        run_to_valid();
        check("t4_oor", 64'(oor_a), 64'd111);
        check("t4_band0", ba(0), 64'd0);
        check("t4_band3", ba(3), 64'd0);

        // 5b: enable dropped for 100 cycles mid-window
        gap();
        start_window(1'b1, 1'b0);
        steps(3000);
        enable   = 1'b0;
        wave_a   = 1'b0;
        sample_a = 1'b0;
        vbefore  = va_count;
        steps(100);
        check("t5b_no_valid", 64'(va_count), 64'(vbefore));
        check("t5b_hold_oor", 64'(oor_a), 64'd111);
        start_window(1'b1, 1'b0);
        run_to_valid();
        check("t5b_latency", 64'(va_cyc), 64'd10000);
        check("t5b_band1", ba(1), 64'd9960);
        check("t5b_oor", 64'(oor_a), 64'd0);

        // 5a: clear at cycle 5000 of a window
        gap();
        start_window(1'b1, 1'b0);
        steps(5000);
        clear = 1'b1;
        step();
        check("t5a_clr_valid", 64'(valid_a), 64'd0);
        check("t5a_clr_band1", ba(1), 64'd0);
        clear    = 1'b0;
        phase    = 0;
        cyc      = 0;
        sample_a = 1'b0;
        run_to_valid();
        check("t5a_latency", 64'(va_cyc), 64'd10000);
        check("t5a_band1", ba(1), 64'd9960);
        check("t5a_oor", 64'(oor_a), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
